camera_emulator: RTL

// - I2C responder at 7-bit address 0x58 that emulates the IR camera for on-board and simulation use.
// - Accepts configuration register writes and a register-pointer write.
// - Answers 16-byte reads with one blob position (10-bit X/Y) in the 3-byte extended format.
// - Connects directly to the pins of the camera driver's I2C master; single clock domain.

---
 rtl/camera_emulator_if.sv | 24 ++
 rtl/camera_emulator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/camera_emulator_if.sv
// Pin bundle between the camera driver's I2C master / blob source and the camera emulator.
interface camera_emulator_if;
  logic       i2c_scl;
  logic       i2c_sda_in;
  logic       i2c_sda;
  logic       i2c_sda_dir;
  logic [9:0] blob_x;
  logic [9:0] blob_y;
  logic       blob_valid;
  logic       cfg_wr;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       busy;

  modport master (
    output i2c_scl, i2c_sda_in, blob_x, blob_y, blob_valid,
    input  i2c_sda, i2c_sda_dir, cfg_wr, cfg_addr, cfg_data, busy
  );

  modport slave (
    input  i2c_scl, i2c_sda_in, blob_x, blob_y, blob_valid,
    output i2c_sda, i2c_sda_dir, cfg_wr, cfg_addr, cfg_data, busy
  );
endinterface

// File: rtl/camera_emulator.sv
// I2C responder emulating the IR camera: config register writes, pointer write,
// and a 16-byte position report carrying one blob in the 3-byte extended format.
module camera_emulator #(
  parameter logic [6:0] I2C_ADDR   = 7'h58,
  parameter logic [7:0] DATA_REG   = 8'h36,
  parameter int         REPORT_LEN = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  camera_emulator_if.slave  bus
);
  localparam int IW = $clog2(REPORT_LEN + 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(REPORT_LEN);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WR_REG, WR_DATA, RD_BYTE, RD_ACK, DONE} state_e;

  state_e        state_q;
  logic [1:0]    scl_sync_q, sda_sync_q;
  logic          scl_prev_q, sda_prev_q;
  logic [3:0]    cnt_q;
  logic [7:0]    sh_q, ptr_q;
  logic [IW-1:0] idx_q;
  logic [9:0]    sx_q, sy_q;
  logic          sv_q;
  logic          dir_q, busy_q, cfg_wr_q;
  logic [7:0]    cfg_addr_q, cfg_data_q;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] sh_d, cur_byte, first_byte;
  logic [2:0] bsel;

  function automatic logic [7:0] rpt_byte(input logic [7:0] ptr, input logic [IW-1:0] idx,
                                          input logic [9:0] x, input logic [9:0] y, input logic v);
    logic [7:0] r;
    r = 8'hFF;
    if (ptr != DATA_REG)          r = 8'h00;
    else if (idx == IW'(0))       r = 8'h00;
    else if (idx >= IW'(4) || !v) r = 8'hFF;
    else if (idx == IW'(1))       r = x[7:0];
    else if (idx == IW'(2))       r = y[7:0];
    else                          r = {y[9:8], x[9:8], 4'h0};
    return r;
  endfunction

  // Synchronizer runs through reset so edge detection is primed when reset lifts.
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[0], bus.i2c_scl};
    sda_sync_q <= {sda_sync_q[0], bus.i2c_sda_in};
    scl_prev_q <= scl_sync_q[1];
    sda_prev_q <= sda_sync_q[1];
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SCL high in both samples means no SCL edge this cycle, so SCL edges win.
  assign start_c  = ~sda_s & sda_prev_q & scl_s & scl_prev_q;
  assign stop_c   = sda_s & ~sda_prev_q & scl_s & scl_prev_q;

  assign sh_d       = {sh_q[6:0], sda_s};
  assign bsel       = 3'(4'd7 - cnt_q);
  assign cur_byte   = rpt_byte(ptr_q, idx_q, sx_q, sy_q, sv_q);
  assign first_byte = rpt_byte(ptr_q, '0, bus.blob_x, bus.blob_y, bus.blob_valid);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      sv_q       <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      cfg_wr_q <= 1'b0;
      if (start_c) begin
        state_q <= ADDR;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        dir_q   <= 1'b0;
      end else if (stop_c) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        dir_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7 && sh_d[7:1] != I2C_ADDR) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              dir_q   <= 1'b1;
              state_q <= ACK_A;
            end
          end
          ACK_A: begin
            if (scl_fall) begin
              if (sh_q[0]) begin
                sx_q    <= bus.blob_x;
                sy_q    <= bus.blob_y;
                sv_q    <= bus.blob_valid;
                idx_q   <= '0;
                dir_q   <= ~first_byte[7];
                cnt_q   <= 4'd1;
                state_q <= RD_BYTE;
              end else begin
                dir_q   <= 1'b0;
                cnt_q   <= '0;
                state_q <= WR_REG;
              end
            end
          end
          // cnt 0..7 shifting, 8 = byte complete (ACK next fall), 9 = ACK on bus.
          WR_REG, WR_DATA: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7 && state_q == WR_DATA) begin
                cfg_wr_q   <= 1'b1;
                cfg_addr_q <= ptr_q;
                cfg_data_q <= sh_d;
                ptr_q      <= ptr_q + 8'd1;
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              dir_q <= 1'b1;
              cnt_q <= 4'd9;
              if (state_q == WR_REG) ptr_q <= sh_q;
            end else if (scl_fall && cnt_q == 4'd9) begin
              dir_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= WR_DATA;
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                dir_q   <= 1'b0;
                cnt_q   <= '0;
                state_q <= RD_ACK;
              end else begin
                dir_q <= ~cur_byte[bsel];
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                if (idx_q < IDX_MAX) idx_q <= idx_q + 1'b1;
                cnt_q <= 4'd1;
              end else begin
                state_q <= DONE;
              end
            end else if (scl_fall && cnt_q == 4'd1) begin
              dir_q   <= ~cur_byte[7];
              state_q <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.i2c_sda     = 1'b0;
  assign bus.i2c_sda_dir = dir_q;
  assign bus.cfg_wr      = cfg_wr_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.cfg_data    = cfg_data_q;
  assign bus.busy        = busy_q;
endmodule
